button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/debounce_ch.sv | 74 +++++++
 rtl/button_conditioner.sv | 75 +++++++
 tb/tb_button_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes in this package).
package stopwatch_pkg;

  // Button bit positions within btn_raw / btn_level / btn_press / btn_release
  localparam int BTN_PAUSE = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_VIEW  = 2;
  localparam int BTN_CLEAR = 3;
  localparam int NUM_BTNS  = 4;

  // Number of lap capture slots; slot 0 means "nothing captured yet"
  localparam int LAP_SLOTS = 3;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef logic [1:0] slot_t;

  // Lap slot advance: 0->1->2->3->1, never returns to 0 except via clear
  function automatic slot_t next_lap_slot(input slot_t cur);
    if (cur == slot_t'(LAP_SLOTS)) begin
      return slot_t'(1);
    end
    return cur + slot_t'(1);
  endfunction

endpackage : stopwatch_pkg

// File: rtl/debounce_ch.sv
// One button channel: synchronizer, stability counter, debounced level, edge pulses.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES clocks raw edge -> level, one more to press/release.
// Backpressure: none; free-running, pulses are single-cycle strobes.
module debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk_50M,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q, level_dly_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchronizer, count disagreement cycles, derive edges
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d       = cnt_q;
    level_d     = level_q;
    if (sync_out == level_q) begin
      // Input agrees with accepted level: any partial count is discarded
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_out;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Edges are taken one cycle behind the level so the pulses are registered
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    release_d   = ~level_q & level_dly_q;
  end

  // State registers; reset aborts any pending change
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule : debounce_ch

// File: rtl/button_conditioner.sv
// Debounces the four stopwatch buttons and runs the pause / lap / view controls.
// Latency: control state updates one clock after the press pulse.
// Backpressure: none; every press pulse is consumed in the cycle it appears.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                pause_state,
  output logic                lap_pulse,
  output logic [1:0]          lap_idx,
  output logic [1:0]          view_sel
);

  // Independent channel per button, no shared counter
  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk_50M     (clk_50M),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw[g]),
      .btn_level   (btn_level[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
    );
  end

  logic  pause_q, pause_d;
  slot_t lap_q, lap_d;
  slot_t view_q, view_d;

  // Control updates; clear overrides every other press in the same cycle
  always_comb begin
    pause_d = pause_q;
    lap_d   = lap_q;
    view_d  = view_q;
    if (btn_press[BTN_CLEAR]) begin
      pause_d = 1'b0;
      lap_d   = '0;
      view_d  = '0;
    end else begin
      if (btn_press[BTN_PAUSE]) pause_d = ~pause_q;
      if (btn_press[BTN_LAP])   lap_d   = next_lap_slot(lap_q);
      if (btn_press[BTN_VIEW])  view_d  = view_q + slot_t'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      pause_q <= 1'b0;
      lap_q   <= '0;
      view_q  <= '0;
    end else begin
      pause_q <= pause_d;
      lap_q   <= lap_d;
      view_q  <= view_d;
    end
  end

  assign pause_state = pause_q;
  assign lap_idx     = lap_q;
  assign view_sel    = view_q;
  assign lap_pulse   = btn_press[BTN_LAP];

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Latency: raw edge -> level after 6 clocks, press pulse on the 7th, control on the 8th.
// Backpressure: n/a.
module tb_button_conditioner;

  logic       clk_50M = 1'b0;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       pause_state;
  logic       lap_pulse;
  logic [1:0] lap_idx;
  logic [1:0] view_sel;

  int n_checks = 0;
  int n_errors = 0;
  int press_cnt [4];
  int rel_cnt   [4];
  int lap_cnt;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk_50M     (clk_50M),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .pause_state (pause_state),
    .lap_pulse   (lap_pulse),
    .lap_idx     (lap_idx),
    .view_sel    (view_sel)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int b = 0; b < 4; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end
    lap_cnt = 0;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_50M);
    #1;
    for (int b = 0; b < 4; b++) begin
      if (btn_press[b] === 1'b1)   press_cnt[b]++;
      if (btn_release[b] === 1'b1) rel_cnt[b]++;
    end
    if (lap_pulse === 1'b1) lap_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   {28'd0, btn_level},   32'd0);
    check({tag, "_press"},   {28'd0, btn_press},   32'd0);
    check({tag, "_release"}, {28'd0, btn_release}, 32'd0);
    check({tag, "_pause"},   {31'd0, pause_state}, 32'd0);
    check({tag, "_lappul"},  {31'd0, lap_pulse},   32'd0);
    check({tag, "_lapidx"},  {30'd0, lap_idx},     32'd0);
    check({tag, "_view"},    {30'd0, view_sel},    32'd0);
  endtask

  logic [1:0] lap_exp [4];

  initial begin
    lap_exp[0] = 2'd1;
    lap_exp[1] = 2'd2;
    lap_exp[2] = 2'd3;
    lap_exp[3] = 2'd1;

    // Reset state
    reset_n = 1'b0;
    btn_raw = 4'b0000;
    clr_cnt();
    run(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    run(2);

    // Clean lap press: level after 6 clocks, pulse on the 7th, idx on the 8th
    clr_cnt();
    btn_raw[1] = 1'b1;
    run(5);
    check("clean_level_early", {31'd0, btn_level[1]}, 32'd0);
    tick();
    check("clean_level", {31'd0, btn_level[1]}, 32'd1);
    check("clean_pulse_early", {31'd0, lap_pulse}, 32'd0);
    tick();
    check("clean_pulse", {31'd0, lap_pulse}, 32'd1);
    check("clean_idx_before", {30'd0, lap_idx}, 32'd0);
    tick();
    check("clean_pulse_end", {31'd0, lap_pulse}, 32'd0);
    check("clean_idx", {30'd0, lap_idx}, 32'd1);
    run(12);
    check("clean_one_press", press_cnt[1], 32'd1);
    btn_raw[1] = 1'b0;
    run(10);

    // Bounce on pause: single-cycle toggles then held high
    clr_cnt();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1; tick();
    btn_raw[0] = 1'b0; tick();
    btn_raw[0] = 1'b1;
    run(15);
    check("bounce_press_cnt", press_cnt[0], 32'd1);
    check("bounce_pause", {31'd0, pause_state}, 32'd1);
    btn_raw[0] = 1'b0;
    run(10);
    check("bounce_release_cnt", rel_cnt[0], 32'd1);
    check("bounce_pause_hold", {31'd0, pause_state}, 32'd1);

    // Clear held then released: one press, one single-cycle release pulse
    clr_cnt();
    btn_raw[3] = 1'b1;
    run(20);
    check("clr_press_cnt", press_cnt[3], 32'd1);
    check("clr_pause", {31'd0, pause_state}, 32'd0);
    check("clr_lapidx", {30'd0, lap_idx}, 32'd0);
    btn_raw[3] = 1'b0;
    run(5);
    check("rel_level_early", {31'd0, btn_level[3]}, 32'd1);
    tick();
    check("rel_level", {31'd0, btn_level[3]}, 32'd0);
    check("rel_pulse_early", {31'd0, btn_release[3]}, 32'd0);
    tick();
    check("rel_pulse", {31'd0, btn_release[3]}, 32'd1);
    tick();
    check("rel_pulse_end", {31'd0, btn_release[3]}, 32'd0);
    run(5);
    check("rel_cnt", rel_cnt[3], 32'd1);
    check("rel_no_second_clear", press_cnt[3], 32'd1);

    // Lap wrap 1,2,3,1
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      btn_raw[1] = 1'b1;
      run(10);
      check($sformatf("lapwrap_%0d", i), {30'd0, lap_idx}, {30'd0, lap_exp[i]});
      btn_raw[1] = 1'b0;
      run(10);
    end
    check("lapwrap_pulses", lap_cnt, 32'd4);

    // A 3-cycle glitch on view is rejected
    clr_cnt();
    btn_raw[2] = 1'b1;
    run(3);
    btn_raw[2] = 1'b0;
    run(10);
    check("glitch_press", press_cnt[2], 32'd0);
    check("glitch_view", {30'd0, view_sel}, 32'd0);

    // Simultaneous pause, lap, view: all take effect (pause 0->1, lap 1->2, view 0->1)
    btn_raw = 4'b0111;
    run(10);
    check("simul_pause", {31'd0, pause_state}, 32'd1);
    check("simul_lap", {30'd0, lap_idx}, 32'd2);
    check("simul_view", {30'd0, view_sel}, 32'd1);
    btn_raw = 4'b0000;
    run(10);

    // Clear together with everything else: clear wins
    btn_raw = 4'b1111;
    run(10);
    check("prio_pause", {31'd0, pause_state}, 32'd0);
    check("prio_lap", {30'd0, lap_idx}, 32'd0);
    check("prio_view", {30'd0, view_sel}, 32'd0);
    btn_raw = 4'b0000;
    run(10);

    // Reset mid-debounce on view, button held through reset
    btn_raw[2] = 1'b1;
    run(10);
    btn_raw[2] = 1'b0;
    run(10);
    check("pre_reset_view", {30'd0, view_sel}, 32'd1);
    btn_raw[2] = 1'b1;
    run(2);
    reset_n = 1'b0;
    tick();
    check_all_zero("midrst");
    run(2);
    reset_n = 1'b1;
    run(5);
    check("rst_level_early", {31'd0, btn_level[2]}, 32'd0);
    tick();
    check("rst_level", {31'd0, btn_level[2]}, 32'd1);
    tick();
    check("rst_press", {31'd0, btn_press[2]}, 32'd1);
    check("rst_view_before", {30'd0, view_sel}, 32'd0);
    tick();
    check("rst_view", {30'd0, view_sel}, 32'd1);
    btn_raw = 4'b0000;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_button_conditioner
